// File: rtl/mux_key_lut_if.sv
// Bus bundle for mux_key_lut: lookup inputs, capture enable and the
// combinational / registered results. The master drives the lookup, the
// slave (the lut itself) returns the selected data.
interface mux_key_lut_if #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
);
  localparam int LUT_W = NR_KEY * (KEY_LEN + DATA_LEN);

  logic [KEY_LEN-1:0]  key;
  logic [DATA_LEN-1:0] default_out;
  logic [LUT_W-1:0]    lut;
  logic                en;
  logic [DATA_LEN-1:0] out;
  logic                hit;
  logic [DATA_LEN-1:0] out_q;
  logic                hit_q;

  modport master (
    output key, default_out, lut, en,
    input  out, hit, out_q, hit_q
  );

  modport slave (
    input  key, default_out, lut, en,
    output out, hit, out_q, hit_q
  );
endinterface

// File: rtl/mux_key_lut.sv
// Key-indexed multiplexer: compares the key against NR_KEY packed {key,data}
// pairs (pair 0 at the LSBs) and returns the data of the lowest-index match,
// or default_out when nothing matches. A registered copy of the result is
// captured on clock edges where en is high.
module mux_key_lut #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_key_lut_if.slave   bus
);
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  w_pair_key  [NR_KEY];
  logic [DATA_LEN-1:0] w_pair_data [NR_KEY];
  logic [DATA_LEN-1:0] w_out;
  logic                w_hit;
  logic [DATA_LEN-1:0] r_out_q;
  logic                r_hit_q;

  // Split the packed lut into per-pair key and data fields.
  for (genvar g = 0; g < NR_KEY; g++) begin : g_pair
    assign w_pair_key[g]  = bus.lut[PAIR_LEN*g + DATA_LEN +: KEY_LEN];
    assign w_pair_data[g] = bus.lut[PAIR_LEN*g +: DATA_LEN];
  end

  // Priority select: scan from the highest index down so the lowest-index
  // matching pair is the last one written and therefore wins.
  always_comb begin
    w_out = bus.default_out;
    w_hit = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (w_pair_key[i] == bus.key) begin
        w_out = w_pair_data[i];
        w_hit = 1'b1;
      end else begin
        w_out = w_out;
        w_hit = w_hit;
      end
    end
  end

  // Pipeline copy of the lookup result, captured only when en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q <= {DATA_LEN{1'b0}};
      r_hit_q <= 1'b0;
    end else if (bus.en) begin
      r_out_q <= w_out;
      r_hit_q <= w_hit;
    end else begin
      r_out_q <= r_out_q;
      r_hit_q <= r_hit_q;
    end
  end

  assign bus.out   = w_out;
  assign bus.hit   = w_hit;
  assign bus.out_q = r_out_q;
  assign bus.hit_q = r_hit_q;
endmodule

// File: tb/tb_mux_key_lut.sv
// Self-checking bench for mux_key_lut: three configurations (3-bit key /
// 32-bit data extension table, 2-bit key byte select, 1-bit key duplicate
// table), directed literal checks plus a per-cycle compare against a
// behavioural lookup model.
module tb_mux_key_lut;
  logic clk;
  logic rst_n;
  logic en;
  logic chk_on;
  int   n_checks;
  int   n_err;

  mux_key_lut_if #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32)) if_a ();
  mux_key_lut_if #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8))  if_b ();
  mux_key_lut_if #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(8))  if_c ();

  mux_key_lut #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  mux_key_lut #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8))  u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  mux_key_lut #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(8))  u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  assign if_a.en = en;
  assign if_b.en = en;
  assign if_c.en = en;

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference lookup: walk the pairs from index 0 upward using shifts and
  // masks, first match wins, otherwise the default.
  function automatic void model(input logic [255:0] lut, input int nk, input int kl,
                                input int dl, input logic [31:0] k, input logic [31:0] dflt,
                                output logic [31:0] o, output logic h);
    logic [255:0] pair;
    logic [63:0]  kmask;
    logic [63:0]  dmask;
    kmask = (64'd1 << kl) - 64'd1;
    dmask = (64'd1 << dl) - 64'd1;
    o = dflt;
    h = 1'b0;
    for (int i = 0; i < nk; i++) begin
      pair = lut >> ((kl + dl) * i);
      if (!h && ((64'(pair[63:0] >> dl) & kmask) == (64'(k) & kmask))) begin
        o = 32'(pair[63:0] & dmask);
        h = 1'b1;
      end
    end
  endfunction

  // Expected registered outputs: model result captured when enabled,
  // cleared immediately by reset.
  logic [31:0] qa_o, qb_o, qc_o;
  logic        qa_h, qb_h, qc_h;
  logic [31:0] ta_o, tb_o, tc_o;
  logic        ta_h, tb_h, tc_h;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa_o = 32'd0; qb_o = 32'd0; qc_o = 32'd0;
      qa_h = 1'b0;  qb_h = 1'b0;  qc_h = 1'b0;
    end else if (en) begin
      model(256'(if_a.lut), 5, 3, 32, 32'(if_a.key), if_a.default_out, ta_o, ta_h);
      model(256'(if_b.lut), 4, 2, 8, 32'(if_b.key), 32'(if_b.default_out), tb_o, tb_h);
      model(256'(if_c.lut), 2, 1, 8, 32'(if_c.key), 32'(if_c.default_out), tc_o, tc_h);
      qa_o = ta_o; qa_h = ta_h;
      qb_o = tb_o; qb_h = tb_h;
      qc_o = tc_o; qc_h = tc_h;
    end
  end

  // Per-cycle compare of every DUT output against the model.
  logic [31:0] eo;
  logic        eh;
  always @(negedge clk) begin
    if (chk_on) begin
      model(256'(if_a.lut), 5, 3, 32, 32'(if_a.key), if_a.default_out, eo, eh);
      chk("a_out", if_a.out, eo);
      chk("a_hit", 32'(if_a.hit), 32'(eh));
      chk("a_out_q", if_a.out_q, qa_o);
      chk("a_hit_q", 32'(if_a.hit_q), 32'(qa_h));
      model(256'(if_b.lut), 4, 2, 8, 32'(if_b.key), 32'(if_b.default_out), eo, eh);
      chk("b_out", 32'(if_b.out), eo);
      chk("b_hit", 32'(if_b.hit), 32'(eh));
      chk("b_out_q", 32'(if_b.out_q), qb_o);
      chk("b_hit_q", 32'(if_b.hit_q), 32'(qb_h));
      model(256'(if_c.lut), 2, 1, 8, 32'(if_c.key), 32'(if_c.default_out), eo, eh);
      chk("c_out", 32'(if_c.out), eo);
      chk("c_hit", 32'(if_c.hit), 32'(eh));
      chk("c_out_q", 32'(if_c.out_q), qc_o);
      chk("c_hit_q", 32'(if_c.hit_q), 32'(qc_h));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_luts();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    if_a.lut = r[174:0];
    if_b.lut = r[214:175];
    if_c.lut = {r[255:240], r[1:0]};
    if_a.default_out = $urandom;
    if_b.default_out = 8'($urandom);
    if_c.default_out = 8'($urandom);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    chk_on   = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b0;
    // pair0 at the LSBs; concatenation lists pair4 first.
    if_a.lut = {3'b101, 32'h0000_0080,   // zero-extend half
                3'b100, 32'h0000_0080,   // zero-extend byte
                3'b010, 32'h0000_0080,   // word
                3'b001, 32'h0000_0080,   // sign-extend half
                3'b000, 32'hFFFF_FF80};  // sign-extend byte
    if_a.default_out = 32'hDEAD_BEEF;
    if_a.key = 3'b000;
    if_b.lut = {2'b11, 8'h44, 2'b10, 8'h33, 2'b01, 8'h22, 2'b00, 8'h11};
    if_b.default_out = 8'hEE;
    if_b.key = 2'b00;
    if_c.lut = {1'b1, 8'h55, 1'b1, 8'hAA};
    if_c.default_out = 8'h0F;
    if_c.key = 1'b1;

    // Reset state, and combinational path alive during reset.
    #1;
    chk("rst_out_q", if_a.out_q, 32'h0000_0000);
    chk("rst_hit_q", 32'(if_a.hit_q), 32'd0);
    chk("rst_comb_out", if_a.out, 32'hFFFF_FF80);
    step();
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Directed combinational lookups.
    if_a.key = 3'b000; #1;
    chk("sext_byte_out", if_a.out, 32'hFFFF_FF80);
    chk("sext_byte_hit", 32'(if_a.hit), 32'd1);
    if_a.key = 3'b100; #1;
    chk("zext_byte_out", if_a.out, 32'h0000_0080);
    chk("zext_byte_hit", 32'(if_a.hit), 32'd1);
    if_a.key = 3'b011; #1;
    chk("absent_out", if_a.out, 32'hDEAD_BEEF);
    chk("absent_hit", 32'(if_a.hit), 32'd0);
    if_b.key = 2'b00; #1;
    chk("bsel_00", 32'(if_b.out), 32'h0000_0011);
    if_b.key = 2'b11; #1;
    chk("bsel_11", 32'(if_b.out), 32'h0000_0044);
    if_c.key = 1'b1; #1;
    chk("dup_low_wins", 32'(if_c.out), 32'h0000_00AA);
    if_c.key = 1'b0; #1;
    chk("dup_miss_out", 32'(if_c.out), 32'h0000_000F);
    chk("dup_miss_hit", 32'(if_c.hit), 32'd0);

    // Registered path: capture, hold, capture, async reset, release.
    step();
    if_a.key = 3'b000;
    en = 1'b1;
    step();
    chk("reg_cap_out_q", if_a.out_q, 32'hFFFF_FF80);
    chk("reg_cap_hit_q", 32'(if_a.hit_q), 32'd1);
    if_a.key = 3'b100;
    en = 1'b0;
    step();
    chk("reg_hold_out_q", if_a.out_q, 32'hFFFF_FF80);
    en = 1'b1;
    step();
    chk("reg_next_out_q", if_a.out_q, 32'h0000_0080);
    if_a.key = 3'b011;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_q", if_a.out_q, 32'h0000_0000);
    chk("async_rst_hit_q", 32'(if_a.hit_q), 32'd0);
    chk("rst_comb_miss", if_a.out, 32'hDEAD_BEEF);
    step();
    rst_n = 1'b1;
    if_a.key = 3'b000;
    en = 1'b0;
    step();
    chk("release_en0_out_q", if_a.out_q, 32'h0000_0000);
    en = 1'b1;
    step();
    chk("release_en1_out_q", if_a.out_q, 32'hFFFF_FF80);
    chk("release_en1_hit_q", 32'(if_a.hit_q), 32'd1);

    // Exhaustive key sweep over random tables; the compare process checks.
    for (int it = 0; it < 8; it++) begin
      rand_luts();
      for (int k = 0; k < 8; k++) begin
        if_a.key = 3'(k);
        if_b.key = 2'(k);
        if_c.key = 1'(k);
        en = 1'($urandom_range(0, 1));
        step();
      end
    end
    step();
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
